// File: rtl/voice_ctrl_pkg.sv
// voice_ctrl_pkg
//   Shared definitions for the voice control writer: register indices,
//   frame FSM state encoding and the default address tag.
//   Optional feature macro: VOICE_CTRL_READBACK_EN (used by importers).
package voice_ctrl_pkg;

  localparam logic [2:0] REG_FREQ_LO = 3'd0;
  localparam logic [2:0] REG_FREQ_HI = 3'd1;
  localparam logic [2:0] REG_PW_LO   = 3'd2;
  localparam logic [2:0] REG_PW_HI   = 3'd3;
  localparam logic [2:0] REG_CTRL    = 3'd4;
  localparam logic [2:0] REG_AD      = 3'd5;
  localparam logic [2:0] REG_SR      = 3'd6;
  localparam logic [2:0] REG_RSVD    = 3'd7;

  localparam logic [4:0] ADDR_TAG_DEFAULT = 5'b10100;

  typedef enum logic [1:0] {
    ST_ADDR   = 2'd0,
    ST_DATA   = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

endpackage

// File: rtl/voice_ctrl_frame_rx.sv
// voice_ctrl_frame_rx
//   Receives two-byte (address, data) frames over a valid/ready byte
//   handshake, checks the address tag, times out a missing data byte and
//   presents one {index, data, strobe} per frame during the COMMIT cycle.
//   Optional feature macro: VOICE_CTRL_READBACK_EN (read frames, rd_o port).
// Ports:
//   main_clk_i   system clock
//   rst_i        synchronous active-low reset
//   cmd_data_i   host byte
//   cmd_valid_i  host byte valid
//   cmd_ready_o  byte accepted when valid && ready at a rising edge
//   frame_err_o  one-cycle pulse on bad address byte or timeout
//   idx_o        register index of the current frame
//   data_o       data byte of the current frame
//   wr_o         write strobe, high during COMMIT of a write frame
//   rd_o         read strobe, high during COMMIT of a read frame (feature)
//
// state     | meaning
// ST_ADDR   | waiting for an address byte, ready high
// ST_DATA   | address latched, waiting for the data byte (timed)
// ST_COMMIT | one cycle, ready low, strobe to the register bank
module voice_ctrl_frame_rx
  import voice_ctrl_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 255,
  parameter logic [4:0] ADDR_TAG       = ADDR_TAG_DEFAULT
) (
  input  logic       main_clk_i,
  input  logic       rst_i,
  input  logic [7:0] cmd_data_i,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  output logic       frame_err_o,
  output logic [2:0] idx_o,
  output logic [7:0] data_o,
`ifdef VOICE_CTRL_READBACK_EN
  output logic       rd_o,
`endif
  output logic       wr_o
);

  localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  // Timeout fires on the edge at which the counter would reach the limit.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q;
  logic             ready_q;
  logic             err_q;
  logic             wr_q;
  logic [2:0]       idx_q;
  logic [7:0]       data_q;
  logic [CNT_W-1:0] cnt_q;
  logic             accept;
  logic             tag_ok;

  assign accept = cmd_valid_i & ready_q;

`ifdef VOICE_CTRL_READBACK_EN
  logic rd_q;
  // Bit 3 is the read flag, so it is excluded from the tag.
  assign tag_ok = (cmd_data_i[7:4] == ADDR_TAG[4:1]);
  assign rd_o   = rd_q;
`else
  assign tag_ok = (cmd_data_i[7:3] == ADDR_TAG);
`endif

  always_ff @(posedge main_clk_i) begin
    if (!rst_i) begin
      state_q <= ST_ADDR;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      wr_q    <= 1'b0;
      idx_q   <= 3'd0;
      data_q  <= 8'h00;
      cnt_q   <= '0;
`ifdef VOICE_CTRL_READBACK_EN
      rd_q    <= 1'b0;
`endif
    end else begin
      err_q <= 1'b0;
      wr_q  <= 1'b0;
`ifdef VOICE_CTRL_READBACK_EN
      rd_q  <= 1'b0;
`endif
      case (state_q)
        ST_ADDR: begin
          ready_q <= 1'b1;
          if (accept) begin
            if (tag_ok) begin
              idx_q <= cmd_data_i[2:0];
              cnt_q <= '0;
`ifdef VOICE_CTRL_READBACK_EN
              if (cmd_data_i[3]) begin
                state_q <= ST_COMMIT;
                ready_q <= 1'b0;
                rd_q    <= 1'b1;
              end else begin
                state_q <= ST_DATA;
              end
`else
              state_q <= ST_DATA;
`endif
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ST_DATA: begin
          // An accept wins over a timeout landing on the same edge.
          if (accept) begin
            data_q  <= cmd_data_i;
            state_q <= ST_COMMIT;
            ready_q <= 1'b0;
            wr_q    <= 1'b1;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= ST_ADDR;
            err_q   <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_COMMIT: begin
          state_q <= ST_ADDR;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= ST_ADDR;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready_o = ready_q;
  assign frame_err_o = err_q;
  assign idx_o       = idx_q;
  assign data_o      = data_q;
  assign wr_o        = wr_q;

endmodule

// File: rtl/voice_ctrl_writer.sv
// voice_ctrl_writer
//   Byte-stream register writer for one synth voice. Frames come in through
//   voice_ctrl_frame_rx; this module holds the register bank and the stage
//   bytes that keep tone_freq and pulse_width from ever being torn.
//   Optional feature macro: VOICE_CTRL_READBACK_EN (register readback).
// Ports:
//   main_clk, rst          clock, synchronous active-low reset
//   cmd_data/valid/ready   host byte handshake
//   frame_err              one-cycle pulse on bad address or timeout
//   tone_freq, pulse_width voice pitch and pulse width
//   waveform_enable        {noise, pulse, saw, triangle}
//   test, en_ringmod, en_sync, gate  voice control bits
//   attack, decay, sustain, rel      envelope settings
//   rd_data, rd_valid      readback byte and strobe (0 without the feature)
module voice_ctrl_writer
  import voice_ctrl_pkg::*;
#(
  parameter int         FREQ_BITS       = 16,
  parameter int         PULSEWIDTH_BITS = 12,
  parameter int         TIMEOUT_CYCLES  = 255,
  parameter logic [4:0] ADDR_TAG        = ADDR_TAG_DEFAULT
) (
  input  logic                       main_clk,
  input  logic                       rst,
  input  logic [7:0]                 cmd_data,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  output logic                       frame_err,
  output logic [FREQ_BITS-1:0]       tone_freq,
  output logic [PULSEWIDTH_BITS-1:0] pulse_width,
  output logic [3:0]                 waveform_enable,
  output logic                       test,
  output logic                       en_ringmod,
  output logic                       en_sync,
  output logic                       gate,
  output logic [3:0]                 attack,
  output logic [3:0]                 decay,
  output logic [3:0]                 sustain,
  output logic [3:0]                 rel,
  output logic [7:0]                 rd_data,
  output logic                       rd_valid
);

  logic [2:0] rx_idx;
  logic [7:0] rx_data;
  logic       rx_wr;

  logic [7:0]                 freq_lo_q;
  logic [7:0]                 pw_lo_q;
  logic [FREQ_BITS-1:0]       freq_q;
  logic [PULSEWIDTH_BITS-1:0] pw_q;
  logic [7:0]                 ctrl_q;
  logic [7:0]                 ad_q;
  logic [7:0]                 sr_q;
  logic [11:0]                pw_full;

`ifdef VOICE_CTRL_READBACK_EN
  logic rx_rd;
`endif

  voice_ctrl_frame_rx #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .ADDR_TAG       (ADDR_TAG)
  ) u_rx (
    .main_clk_i  (main_clk),
    .rst_i       (rst),
    .cmd_data_i  (cmd_data),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .frame_err_o (frame_err),
    .idx_o       (rx_idx),
    .data_o      (rx_data),
`ifdef VOICE_CTRL_READBACK_EN
    .rd_o        (rx_rd),
`endif
    .wr_o        (rx_wr)
  );

  // Narrower pulse widths simply drop the top bits of register 3.
  assign pw_full = {rx_data[3:0], pw_lo_q};

  always_ff @(posedge main_clk) begin
    if (!rst) begin
      freq_lo_q <= 8'h00;
      pw_lo_q   <= 8'h00;
      freq_q    <= '0;
      pw_q      <= '0;
      ctrl_q    <= 8'h00;
      ad_q      <= 8'h00;
      sr_q      <= 8'h00;
    end else if (rx_wr) begin
      case (rx_idx)
        REG_FREQ_LO: freq_lo_q <= rx_data;
        REG_FREQ_HI: freq_q    <= FREQ_BITS'({rx_data, freq_lo_q});
        REG_PW_LO:   pw_lo_q   <= rx_data;
        REG_PW_HI:   pw_q      <= pw_full[PULSEWIDTH_BITS-1:0];
        REG_CTRL:    ctrl_q    <= rx_data;
        REG_AD:      ad_q      <= rx_data;
        REG_SR:      sr_q      <= rx_data;
        default:     ;
      endcase
    end
  end

  assign tone_freq       = freq_q;
  assign pulse_width     = pw_q;
  assign waveform_enable = ctrl_q[7:4];
  assign test            = ctrl_q[3];
  assign en_ringmod      = ctrl_q[2];
  assign en_sync         = ctrl_q[1];
  assign gate            = ctrl_q[0];
  assign attack          = ad_q[7:4];
  assign decay           = ad_q[3:0];
  assign sustain         = sr_q[7:4];
  assign rel             = sr_q[3:0];

`ifdef VOICE_CTRL_READBACK_EN
  logic [7:0]  rd_data_q;
  logic        rd_valid_q;
  logic [7:0]  rd_mux;
  logic [11:0] pw_ext;
  logic [15:0] freq_ext;

  assign pw_ext   = 12'(pw_q);
  assign freq_ext = 16'(freq_q);

  always_comb begin
    rd_mux = 8'h00;
    case (rx_idx)
      REG_FREQ_LO: rd_mux = freq_lo_q;
      REG_FREQ_HI: rd_mux = freq_ext[15:8];
      REG_PW_LO:   rd_mux = pw_lo_q;
      REG_PW_HI:   rd_mux = {4'b0000, pw_ext[11:8]};
      REG_CTRL:    rd_mux = ctrl_q;
      REG_AD:      rd_mux = ad_q;
      REG_SR:      rd_mux = sr_q;
      REG_RSVD:    rd_mux = 8'h00;
      default:     rd_mux = 8'h00;
    endcase
  end

  always_ff @(posedge main_clk) begin
    if (!rst) begin
      rd_data_q  <= 8'h00;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rx_rd;
      if (rx_rd) rd_data_q <= rd_mux;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
`else
  assign rd_data  = 8'h00;
  assign rd_valid = 1'b0;
`endif

endmodule

// File: tb/tb_voice_ctrl_writer.sv
module tb_voice_ctrl_writer;

  logic        main_clk;
  logic        rst;
  logic [7:0]  cmd_data;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        frame_err;
  logic [15:0] tone_freq;
  logic [11:0] pulse_width;
  logic [3:0]  waveform_enable;
  logic        test;
  logic        en_ringmod;
  logic        en_sync;
  logic        gate;
  logic [3:0]  attack, decay, sustain, rel;
  logic [7:0]  rd_data;
  logic        rd_valid;

  voice_ctrl_writer dut (
    .main_clk        (main_clk),
    .rst             (rst),
    .cmd_data        (cmd_data),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .frame_err       (frame_err),
    .tone_freq       (tone_freq),
    .pulse_width     (pulse_width),
    .waveform_enable (waveform_enable),
    .test            (test),
    .en_ringmod      (en_ringmod),
    .en_sync         (en_sync),
    .gate            (gate),
    .attack          (attack),
    .decay           (decay),
    .sustain         (sustain),
    .rel             (rel),
    .rd_data         (rd_data),
    .rd_valid        (rd_valid)
  );

  initial main_clk = 1'b0;
  always #5 main_clk = ~main_clk;

  // {freq16, pw12, ctrl8 = {wave,test,ring,sync,gate}, ad8, sr8}
  logic [51:0] dut_outs;
  assign dut_outs = {tone_freq, pulse_width, waveform_enable, test, en_ringmod,
                     en_sync, gate, attack, decay, sustain, rel};

  function automatic logic [51:0] mk(input logic [15:0] f, input logic [11:0] p,
                                     input logic [7:0] c, input logic [7:0] ad,
                                     input logic [7:0] sr);
    return {f, p, c, ad, sr};
  endfunction

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  d;
    logic [51:0] exp;
  } vec_t;

  vec_t        tbl [14];
  logic [51:0] sb [$];
  logic [51:0] model_outs;
  int          total = 0;
  int          bad = 0;
  int          err_seen = 0;
  int          low_len = 0;
  int          e0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Output monitor: counts frame_err pulses and, when ready returns high
  // after a commit, pops the expected register snapshot.
  always @(negedge main_clk) begin
    if (frame_err) err_seen++;
    if (!cmd_ready) begin
      low_len++;
    end else begin
      if (low_len != 0 && sb.size() > 0) begin
        logic [51:0] e;
        e = sb.pop_front();
        chk("commit_outs", 64'(dut_outs), 64'(e));
        chk("ready_low_len", 64'(low_len), 64'd1);
      end
      low_len = 0;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge main_clk);
    while (!cmd_ready && n < 50) begin
      @(negedge main_clk);
      n++;
    end
    if (!cmd_ready) begin
      total++;
      bad++;
      $display("FAIL ready_wait: got cmd_ready=0 want 1 within 50 cycles");
    end
    cmd_data  = b;
    cmd_valid = 1'b1;
    @(posedge main_clk);
    #1 cmd_valid = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish want finish before 300us");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    cmd_valid = 1'b0;
    cmd_data = 8'h00;
    model_outs = '0;

    tbl[0]  = '{8'hA0, 8'h34, mk(16'h0000, 12'h000, 8'h00, 8'h00, 8'h00)};
    tbl[1]  = '{8'hA1, 8'h12, mk(16'h1234, 12'h000, 8'h00, 8'h00, 8'h00)};
    tbl[2]  = '{8'hA4, 8'h41, mk(16'h1234, 12'h000, 8'h41, 8'h00, 8'h00)};
    tbl[3]  = '{8'hA4, 8'h40, mk(16'h1234, 12'h000, 8'h40, 8'h00, 8'h00)};
    tbl[4]  = '{8'hA2, 8'hCD, mk(16'h1234, 12'h000, 8'h40, 8'h00, 8'h00)};
    tbl[5]  = '{8'hA3, 8'hF7, mk(16'h1234, 12'h7CD, 8'h40, 8'h00, 8'h00)};
    tbl[6]  = '{8'hA5, 8'hC9, mk(16'h1234, 12'h7CD, 8'h40, 8'hC9, 8'h00)};
    tbl[7]  = '{8'hA6, 8'h3E, mk(16'h1234, 12'h7CD, 8'h40, 8'hC9, 8'h3E)};
    tbl[8]  = '{8'hA7, 8'hFF, mk(16'h1234, 12'h7CD, 8'h40, 8'hC9, 8'h3E)};
    tbl[9]  = '{8'hA0, 8'h11, mk(16'h1234, 12'h7CD, 8'h40, 8'hC9, 8'h3E)};
    tbl[10] = '{8'hA0, 8'h22, mk(16'h1234, 12'h7CD, 8'h40, 8'hC9, 8'h3E)};
    tbl[11] = '{8'hA1, 8'hAB, mk(16'hAB22, 12'h7CD, 8'h40, 8'hC9, 8'h3E)};
    tbl[12] = '{8'hA1, 8'hCD, mk(16'hCD22, 12'h7CD, 8'h40, 8'hC9, 8'h3E)};
    tbl[13] = '{8'hA4, 8'hFF, mk(16'hCD22, 12'h7CD, 8'hFF, 8'hC9, 8'h3E)};

    // reset
    repeat (2) @(posedge main_clk);
    @(negedge main_clk);
    chk("rst_outs", 64'(dut_outs), 64'd0);
    chk("rst_ready", 64'(cmd_ready), 64'd0);
    chk("rst_err", 64'(frame_err), 64'd0);
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    rst = 1'b1;
    @(negedge main_clk);
    chk("ready_after_rst", 64'(cmd_ready), 64'd1);

    // table of back-to-back write frames
    for (int i = 0; i < 14; i++) begin
      send_byte(tbl[i].a);
      sb.push_back(tbl[i].exp);
      model_outs = tbl[i].exp;
      send_byte(tbl[i].d);
    end
    repeat (3) @(negedge main_clk);

    // bad address byte
    e0 = err_seen;
    send_byte(8'h55);
    repeat (3) @(negedge main_clk);
    chk("bad_addr_err", 64'(err_seen), 64'(e0 + 1));
    chk("bad_addr_outs", 64'(dut_outs), 64'(model_outs));

`ifndef VOICE_CTRL_READBACK_EN
    e0 = err_seen;
    send_byte(8'hA8);
    repeat (3) @(negedge main_clk);
    chk("bit3_tag_err", 64'(err_seen), 64'(e0 + 1));
`endif

    // timeout after an address byte, then a stray byte rejected as address
    e0 = err_seen;
    send_byte(8'hA6);
    repeat (254) @(posedge main_clk);
    #1 chk("timeout_early", 64'(frame_err), 64'd0);
    @(posedge main_clk);
    #1 chk("timeout_edge", 64'(frame_err), 64'd1);
    send_byte(8'h7F);
    repeat (3) @(negedge main_clk);
    chk("timeout_errs", 64'(err_seen), 64'(e0 + 2));
    chk("timeout_outs", 64'(dut_outs), 64'(model_outs));

    // data byte accepted on the very edge the timeout would fire
    e0 = err_seen;
    send_byte(8'hA5);
    repeat (254) @(posedge main_clk);
    #1;
    cmd_data  = 8'h5A;
    cmd_valid = 1'b1;
    model_outs = mk(16'hCD22, 12'h7CD, 8'hFF, 8'h5A, 8'h3E);
    sb.push_back(model_outs);
    @(posedge main_clk);
    #1 cmd_valid = 1'b0;
    repeat (4) @(negedge main_clk);
    chk("accept_at_limit_err", 64'(err_seen), 64'(e0));

    // reset mid-frame discards the address byte
    send_byte(8'hA1);
    @(negedge main_clk);
    rst = 1'b0;
    repeat (2) @(negedge main_clk);
    chk("midrst_outs", 64'(dut_outs), 64'd0);
    rst = 1'b1;
    model_outs = '0;
    e0 = err_seen;
    send_byte(8'h12);
    repeat (3) @(negedge main_clk);
    chk("midrst_err", 64'(err_seen), 64'(e0 + 1));
    chk("midrst_outs2", 64'(dut_outs), 64'd0);

    // commits using stage values cleared by reset
    send_byte(8'hA1);
    model_outs = mk(16'h5600, 12'h000, 8'h00, 8'h00, 8'h00);
    sb.push_back(model_outs);
    send_byte(8'h56);
    send_byte(8'hA3);
    model_outs = mk(16'h5600, 12'hB00, 8'h00, 8'h00, 8'h00);
    sb.push_back(model_outs);
    send_byte(8'h0B);

`ifdef VOICE_CTRL_READBACK_EN
    send_byte(8'hA6);
    model_outs = mk(16'h5600, 12'hB00, 8'h00, 8'h00, 8'h8A);
    sb.push_back(model_outs);
    send_byte(8'h8A);
    send_byte(8'hAE);
    @(posedge main_clk);
    #1;
    chk("rd_valid_hi", 64'(rd_valid), 64'd1);
    chk("rd_data", 64'(rd_data), 64'h8A);
    @(posedge main_clk);
    #1 chk("rd_valid_lo", 64'(rd_valid), 64'd0);
`else
    @(negedge main_clk);
    chk("rd_valid_off", 64'(rd_valid), 64'd0);
    chk("rd_data_off", 64'(rd_data), 64'd0);
`endif

    repeat (4) @(negedge main_clk);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/voice_ctrl_writer.md
Name: voice_ctrl_writer

Overview:
- Byte-stream register writer that drives the control inputs of one synth voice: frequency, waveform enables, pulse width, ring-mod/sync enables, test, gate, ADSR.
- Sits between a host byte source (UART/SPI front end) and a voice instance; it is the initiator for the voice's parameter interface.
- Decodes two-byte write frames (address, data) with a valid/ready handshake.
- Double-buffers multi-byte fields so the voice never sees a torn frequency or pulse width.

Parameters:
FREQ_BITS, 16, width of tone_freq output; fixed at 16 by the register map.
PULSEWIDTH_BITS, 12, width of pulse_width output; 9..12 supported, upper bits of register 3 dropped.
TIMEOUT_CYCLES, 255, main_clk cycles allowed between an address byte and its data byte.
ADDR_TAG, 5'b10100, required value of address byte bits [7:3].

Ports:
main_clk  input  1  system clock.
rst  input  1  synchronous, active-low reset; sampled on the main_clk rising edge.
cmd_data  input  8  byte from host.
cmd_valid  input  1  cmd_data valid.
cmd_ready  output  1  byte accepted when cmd_valid && cmd_ready at a rising edge.
frame_err  output  1  one-cycle pulse on a bad address byte or a timeout.
tone_freq  output  FREQ_BITS  to voice.
pulse_width  output  PULSEWIDTH_BITS  to voice.
waveform_enable  output  4  {noise, pulse, saw, triangle}.
test, en_ringmod, en_sync, gate  output  1 each  to voice.
attack, decay, sustain, rel  output  4 each  to voice.
rd_data  output  8  readback byte (optional feature).
rd_valid  output  1  readback strobe (optional feature).

Behaviour:
- Reset (rst==0 at an edge):
  - All outputs and staging registers 0; state ADDR.
  - cmd_ready=0 during the reset cycle, 1 on the first cycle after.
  - Reset mid-frame discards the partial frame.
- Register map (index = address byte [2:0]):
  - 0: freq[7:0], staged.
  - 1: freq[15:8]; commits {data, stage0} to tone_freq.
  - 2: pw[7:0], staged.
  - 3: pw[11:8] in data[3:0]; commits pulse_width.
  - 4: control = {noise, pulse, saw, tri, test, ringmod, sync, gate}.
  - 5: attack = data[7:4], decay = data[3:0].
  - 6: sustain = data[7:4], rel = data[3:0].
  - 7: reserved; the write is accepted and ignored.
- FSM, ADDR state:
  - cmd_ready=1.
  - Accepted byte with [7:3]==ADDR_TAG: latch index, clear timeout counter, go to DATA.
  - Any other byte: drop it, pulse frame_err next cycle, stay in ADDR.
- FSM, DATA state:
  - cmd_ready=1; any byte value is accepted as data.
  - On accept: latch the byte, go to COMMIT.
  - Timeout counter increments each cycle with no accept. When it reaches TIMEOUT_CYCLES: go to ADDR and pulse frame_err. The counter reaching the limit in the same cycle as an accept counts as an accept.
- FSM, COMMIT state (one cycle):
  - cmd_ready=0.
  - The target output register updates at the end of COMMIT.
  - Latency: data accepted at edge N, output visible after edge N+1.
  - Returns to ADDR.
- Staged writes (regs 0, 2):
  - Update only the stage register; outputs unchanged.
  - A second write to 0 before 1 overwrites the stage.
  - Writing 1 without a prior 0 uses the current stage value (reset 0).
- Gate: follows the reg-4 bit directly. Rewriting gate=1 while already 1 produces no edge; the host must write 0 then 1 to retrigger.
- Maximum throughput: one frame per 3 cycles.

Optional Feature:
- Macro VOICE_CTRL_READBACK_EN.
- Defined:
  - Address byte bit 3 is ignored by tag matching; tag compares bits [7:4] against ADDR_TAG[4:1].
  - bit3=1 marks a read: no DATA byte is expected. Next cycle the FSM enters COMMIT.
  - rd_data = committed register value (reg 0/2 return the staged byte; reg 3 returns {4'b0, pw[11:8]}; reg 7 returns 0). rd_valid pulses 1 cycle at the end of COMMIT.
- Undefined: rd_data=0, rd_valid=0 constant; tag compares all of [7:3].

Decomposition:
- Package voice_ctrl_pkg holds:
  - register index localparams (REG_FREQ_LO..REG_SR);
  - FSM state encoding (ADDR, DATA, COMMIT);
  - the ADDR_TAG default.
- One sub-module, voice_ctrl_frame_rx: handshake, tag check, timeout FSM; emits {index, data, write strobe}.
- The top holds the register bank and staging.

Test Plan:
- Reset: rst=0 for 2 cycles -> all outputs 0, cmd_ready=0; first cycle after rst=1 -> cmd_ready=1.
- Bytes 0xA0,0x34,0xA1,0x12 back-to-back -> tone_freq stays 0 until the 0x12 commit, then 0x1234; cmd_ready low exactly one cycle after each data byte.
- Bytes 0xA4,0x41 -> waveform_enable=4'b0100, gate=1. Then 0xA4,0x40 -> gate=0, waveform unchanged.
- Byte 0x55 in ADDR -> frame_err pulse, no register change. Then 0xA5,0xC9 -> attack=0xC, decay=0x9.
- 0xA6 then idle 255 cycles -> frame_err, state ADDR. The following 0x7F is treated as an address and rejected (second frame_err).
- With VOICE_CTRL_READBACK_EN: write 0xA6,0x8A, then 0xAE -> rd_valid one cycle, rd_data=0x8A.
